digit_edge_detect: RTL
======================

DIGIT_EDGE_DETECT -- requirements
Module: digit_edge_detect

Interface
REQ-001 Parameter H_ACTIVE, default 640: active pixels per row; legal range 2..1023.
REQ-002 Parameter V_ACTIVE, default 480: active rows per frame; legal range 2..1023.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  pixel qualifier; iRow/iCol/iBWData are sampled only when en=1.
REQ-006 iRow  input  10  row address of the current pixel.
REQ-007 iCol  input  10  column address of the current pixel.
REQ-008 iBWData  input  10  binarised pixel; 10'h000 = black (digit stroke), any other value = white.
REQ-009 oEdge_Row  output  20  [19:10] bottom (max) row, [9:0] top (min) row of the committed digit box.
REQ-010 oEdge_Col  output  20  [19:10] right (max) column, [9:0] left (min) column of the committed digit box.
REQ-011 oFound  output  1  committed frame contained at least one counted black pixel.
REQ-012 oValid  output  1  one-cycle pulse marking a new commit of oEdge_Row/oEdge_Col/oFound.

Function
REQ-013 States: WAIT_SOF, SCAN, COMMIT; 2-bit encoding.
REQ-014 A pixel is in range only when iRow < V_ACTIVE and iCol < H_ACTIVE; out-of-range pixels change no state.
REQ-015 SOF = en and iRow=0 and iCol=0; EOF = en and iRow=V_ACTIVE-1 and iCol=H_ACTIVE-1.
REQ-016 WAIT_SOF: pixels are ignored until SOF; on SOF, accumulators are loaded from that pixel and the state goes to SCAN.
REQ-017 SCAN: each counted black pixel updates running min_row, max_row, min_col, max_col and sets hit.
REQ-018 Accumulator values when no pixel is counted: min_row=min_col=10'h3FF, max_row=max_col=0, hit=0.
REQ-019 SCAN plus EOF: the EOF pixel is included in the accumulators and the state goes to COMMIT.
REQ-020 SCAN plus SOF before EOF: the partial frame is discarded, accumulators restart from the SOF pixel, the state stays SCAN and no commit occurs.
REQ-021 COMMIT lasts one cycle: outputs are registered from the accumulators and oValid=1 for exactly that cycle.
REQ-022 Latency: with the EOF pixel sampled on edge k, outputs update and oValid rises on edge k+1.
REQ-023 COMMIT plus SOF on the same cycle: SOF is accepted as the first pixel of the next frame (next state SCAN); otherwise the next state is WAIT_SOF.
REQ-024 Commit with hit=0: oFound=0 and oEdge_Row=oEdge_Col=0.
REQ-025 Commit with hit=1: oFound=1, oEdge_Row={max_row,min_row}, oEdge_Col={max_col,min_col}.
REQ-026 Committed outputs hold their value until the next commit, stable for the whole following frame.
REQ-027 Min/max comparisons are unsigned 10-bit.

Reset
REQ-028 When rst=0, asynchronously: state=WAIT_SOF, accumulators at the REQ-018 values, oEdge_Row=0, oEdge_Col=0, oFound=0, oValid=0.
REQ-029 Reset mid-frame discards the partial frame; after release, nothing is committed before a complete SOF..EOF frame.

Configuration
REQ-030 Macro DIGIT_NOISE_FILTER_EN defined: a black pixel is counted only if the previous en-qualified pixel in the same row was also black; the previous-pixel flag clears at iCol=0 and at SOF.
REQ-031 Macro DIGIT_NOISE_FILTER_EN undefined: every in-range black pixel is counted; no filter logic is present.

Structure
REQ-032 Package digit_pkg holds the state enumeration, BLACK_PIX=10'h000, coordinate width 10, and the H_ACTIVE/V_ACTIVE defaults.
REQ-033 The noise filter is sub-module digit_run_filter (inputs: en, iCol, black; output: count_en), instantiated only under DIGIT_NOISE_FILTER_EN.

Verification (H_ACTIVE=16, V_ACTIVE=12)
REQ-034 Black rectangle rows 3..8, cols 5..10, rest white -> one oValid pulse on the edge after EOF; oEdge_Row={8,3}, oEdge_Col={10,5}, oFound=1.
REQ-035 All-white frame -> oValid pulse, oFound=0, oEdge_Row=0, oEdge_Col=0.
REQ-036 Single black pixel (7,9), filter macro off -> oEdge_Row={7,7}, oEdge_Col={9,9}; filter macro on -> oFound=0.
REQ-037 rst low at row 6 of a frame, then two full frames with rectangle rows 2..4 -> no commit for the aborted frame; the first oValid after reset carries {4,2}.
REQ-038 Back-to-back frames with SOF arriving in the COMMIT cycle, frame 2 rectangle cols 1..14 -> both frames commit; frame 2 gives oEdge_Col={14,1}.
REQ-039 SOF reissued at row 5 of a frame that was black at row 1, followed by a full frame -> no commit at the restart; the following commit excludes row 1.

Source files
------------

// File: rtl/digit_edge_detect_pkg.sv
// Shared definitions for the digit bounding-box detector: coordinate width,
// pixel encoding, default frame geometry and FSM state constants.
package digit_pkg;

  localparam int COORD_W      = 10;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  localparam logic [COORD_W-1:0] BLACK_PIX    = 10'h000;
  localparam logic [COORD_W-1:0] ACC_MIN_INIT = 10'h3FF;
  localparam logic [COORD_W-1:0] ACC_MAX_INIT = 10'h000;

  typedef logic [1:0] state_t;
  localparam state_t WAIT_SOF = 2'd0;
  localparam state_t SCAN     = 2'd1;
  localparam state_t COMMIT   = 2'd2;

endpackage

// File: rtl/digit_edge_detect_if.sv
// Pixel stream in, committed bounding box out. The source side drives the
// pixel fields; the detector drives the result fields.
interface digit_edge_detect_if;
  import digit_pkg::*;

  logic                 en;
  logic [COORD_W-1:0]   iRow;
  logic [COORD_W-1:0]   iCol;
  logic [COORD_W-1:0]   iBWData;
  logic [2*COORD_W-1:0] oEdge_Row;
  logic [2*COORD_W-1:0] oEdge_Col;
  logic                 oFound;
  logic                 oValid;

  modport master (
    output en, iRow, iCol, iBWData,
    input  oEdge_Row, oEdge_Col, oFound, oValid
  );

  modport slave (
    input  en, iRow, iCol, iBWData,
    output oEdge_Row, oEdge_Col, oFound, oValid
  );

endinterface

// File: rtl/digit_run_filter.sv
// Isolated-pixel rejection: a black pixel counts only when the previous
// qualified pixel of the same row was black. Built only with DIGIT_NOISE_FILTER_EN.
`ifdef DIGIT_NOISE_FILTER_EN
module digit_run_filter
  import digit_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [COORD_W-1:0] iCol,
  input  logic               black,
  output logic               count_en
);

  logic prevBlack;

  // Column 0 (which includes SOF) never has a same-row predecessor.
  assign count_en = en && black && prevBlack && (iCol != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prevBlack <= 1'b0;
    end else if (en) begin
      prevBlack <= black;
    end
  end

endmodule
`endif

// File: rtl/digit_edge_detect.sv
// Tracks the bounding box of black pixels per frame and commits it one cycle
// after EOF. Optional DIGIT_NOISE_FILTER_EN inserts digit_run_filter.
module digit_edge_detect
  import digit_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input logic               clk,
  input logic               rst,
  digit_edge_detect_if.slave pix
);

  localparam logic [COORD_W-1:0] H_LIM  = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_LIM  = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_ACTIVE - 1);

  state_t             state;
  logic [COORD_W-1:0] minRow, maxRow, minCol, maxCol;
  logic               hit;
  logic [COORD_W-1:0] seedMinRow, seedMaxRow, seedMinCol, seedMaxCol;
  logic [COORD_W-1:0] foldMinRow, foldMaxRow, foldMinCol, foldMaxCol;
  logic               seedHit, foldHit;
  logic               inRange, sof, eof, black, countEn;
  logic [2*COORD_W-1:0] edgeRow, edgeCol;
  logic               found, valid;

  assign inRange = pix.en && (pix.iRow < V_LIM) && (pix.iCol < H_LIM);
  assign sof     = pix.en && (pix.iRow == '0) && (pix.iCol == '0);
  assign eof     = pix.en && (pix.iRow == V_LAST) && (pix.iCol == H_LAST);
  assign black   = (pix.iBWData == BLACK_PIX);

`ifdef DIGIT_NOISE_FILTER_EN
  digit_run_filter uRunFilter (
    .clk      (clk),
    .rst      (rst),
    .en       (inRange),
    .iCol     (pix.iCol),
    .black    (black),
    .count_en (countEn)
  );
`else
  assign countEn = inRange && black;
`endif

  // seed* restarts a frame from the current pixel; fold* merges it into the box.
  always_comb begin
    seedMinRow = ACC_MIN_INIT;
    seedMaxRow = ACC_MAX_INIT;
    seedMinCol = ACC_MIN_INIT;
    seedMaxCol = ACC_MAX_INIT;
    seedHit    = 1'b0;
    foldMinRow = minRow;
    foldMaxRow = maxRow;
    foldMinCol = minCol;
    foldMaxCol = maxCol;
    foldHit    = hit;
    if (countEn) begin
      seedMinRow = pix.iRow;
      seedMaxRow = pix.iRow;
      seedMinCol = pix.iCol;
      seedMaxCol = pix.iCol;
      seedHit    = 1'b1;
      if (pix.iRow < minRow) foldMinRow = pix.iRow;
      if (pix.iRow > maxRow) foldMaxRow = pix.iRow;
      if (pix.iCol < minCol) foldMinCol = pix.iCol;
      if (pix.iCol > maxCol) foldMaxCol = pix.iCol;
      foldHit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= WAIT_SOF;
      minRow  <= ACC_MIN_INIT;
      maxRow  <= ACC_MAX_INIT;
      minCol  <= ACC_MIN_INIT;
      maxCol  <= ACC_MAX_INIT;
      hit     <= 1'b0;
      edgeRow <= '0;
      edgeCol <= '0;
      found   <= 1'b0;
      valid   <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        WAIT_SOF: begin
          if (sof) begin
            {minRow, maxRow, minCol, maxCol, hit} <=
              {seedMinRow, seedMaxRow, seedMinCol, seedMaxCol, seedHit};
            state <= SCAN;
          end
        end
        SCAN: begin
          // A fresh SOF abandons the partial frame without committing it.
          if (sof) begin
            {minRow, maxRow, minCol, maxCol, hit} <=
              {seedMinRow, seedMaxRow, seedMinCol, seedMaxCol, seedHit};
          end else begin
            {minRow, maxRow, minCol, maxCol, hit} <=
              {foldMinRow, foldMaxRow, foldMinCol, foldMaxCol, foldHit};
          end
          if (eof) state <= COMMIT;
        end
        COMMIT: begin
          edgeRow <= hit ? {maxRow, minRow} : '0;
          edgeCol <= hit ? {maxCol, minCol} : '0;
          found   <= hit;
          valid   <= 1'b1;
          // seed* already holds the reset values when this pixel is not a counted SOF.
          {minRow, maxRow, minCol, maxCol, hit} <= sof ?
            {seedMinRow, seedMaxRow, seedMinCol, seedMaxCol, seedHit} :
            {ACC_MIN_INIT, ACC_MAX_INIT, ACC_MIN_INIT, ACC_MAX_INIT, 1'b0};
          state <= sof ? SCAN : WAIT_SOF;
        end
        default: state <= WAIT_SOF;
      endcase
    end
  end

  assign pix.oEdge_Row = edgeRow;
  assign pix.oEdge_Col = edgeCol;
  assign pix.oFound    = found;
  assign pix.oValid    = valid;

endmodule
